// File: rtl/logic_pkg.sv
// Shared definitions for the logic-op arbiter: op encodings, data width and FSM states.
package logic_pkg;

    localparam int unsigned WIDTH = 32;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/logic_unit32.sv
// Shared combinational bitwise logic unit: y = f(op, a, b), no carries or flags.
module logic_unit32
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_unit32 between two valid/ready requesters.
module logic_op_arbiter
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             r0_req_valid,
    output logic             r0_req_ready,
    input  logic [1:0]       r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_resp_valid,
    input  logic             r0_resp_ready,

    input  logic             r1_req_valid,
    output logic             r1_req_ready,
    input  logic [1:0]       r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_resp_valid,
    input  logic             r1_resp_ready,

    output logic [WIDTH-1:0] resp_data,
    output logic             busy
);

    state_t           state;
    logic             last_grant;
    logic             grant_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] unit_y;

    logic             any_req_c;
    logic             grant_c;
    logic [1:0]       sel_op_c;
    logic [WIDTH-1:0] sel_a_c;
    logic [WIDTH-1:0] sel_b_c;
    logic             owner_resp_ready_c;

    // Grant selection: on a tie the requester that did not win last time goes next.
    always_comb begin
        any_req_c = r0_req_valid | r1_req_valid;
        grant_c   = 1'b0;
        if (r0_req_valid && r1_req_valid) begin
            grant_c = ~last_grant;
        end else begin
            grant_c = ~r0_req_valid;
        end

        r0_req_ready = (state == ST_IDLE) && any_req_c && !grant_c;
        r1_req_ready = (state == ST_IDLE) && any_req_c &&  grant_c;

        sel_op_c = grant_c ? r1_op : r0_op;
        sel_a_c  = grant_c ? r1_a  : r0_a;
        sel_b_c  = grant_c ? r1_b  : r0_b;

        owner_resp_ready_c = grant_q ? r1_resp_ready : r0_resp_ready;
    end

    logic_unit32 #(
        .WIDTH (WIDTH)
    ) u_logic_unit (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (unit_y)
    );

    // FSM plus capture, result and handshake registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            last_grant    <= 1'b1;
            grant_q       <= 1'b0;
            op_q          <= 2'b00;
            a_q           <= '0;
            b_q           <= '0;
            resp_data     <= '0;
            r0_resp_valid <= 1'b0;
            r1_resp_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req_c) begin
                        grant_q <= grant_c;
                        op_q    <= sel_op_c;
                        a_q     <= sel_a_c;
                        b_q     <= sel_b_c;
                        busy    <= 1'b1;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_data     <= unit_y;
                    r0_resp_valid <= !grant_q;
                    r1_resp_valid <=  grant_q;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    // Only the owning requester's resp_ready completes the op.
                    if (owner_resp_ready_c) begin
                        last_grant    <= grant_q;
                        r0_resp_valid <= 1'b0;
                        r1_resp_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    r0_resp_valid <= 1'b0;
                    r1_resp_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed self-checking bench for logic_op_arbiter with hand-computed expected values.
module tb_logic_op_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_req_valid, r0_req_ready, r0_resp_valid, r0_resp_ready;
    logic [1:0]  r0_op;
    logic [31:0] r0_a, r0_b;
    logic        r1_req_valid, r1_req_ready, r1_resp_valid, r1_resp_ready;
    logic [1:0]  r1_op;
    logic [31:0] r1_a, r1_b;
    logic [31:0] resp_data;
    logic        busy;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    logic_op_arbiter #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .r0_req_valid  (r0_req_valid),
        .r0_req_ready  (r0_req_ready),
        .r0_op         (r0_op),
        .r0_a          (r0_a),
        .r0_b          (r0_b),
        .r0_resp_valid (r0_resp_valid),
        .r0_resp_ready (r0_resp_ready),
        .r1_req_valid  (r1_req_valid),
        .r1_req_ready  (r1_req_ready),
        .r1_op         (r1_op),
        .r1_a          (r1_a),
        .r1_b          (r1_b),
        .r1_resp_valid (r1_resp_valid),
        .r1_resp_ready (r1_resp_ready),
        .resp_data     (resp_data),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " r0_req_ready"},  32'(r0_req_ready),  32'h0);
        check({tag, " r1_req_ready"},  32'(r1_req_ready),  32'h0);
        check({tag, " r0_resp_valid"}, 32'(r0_resp_valid), 32'h0);
        check({tag, " r1_resp_valid"}, 32'(r1_resp_valid), 32'h0);
        check({tag, " busy"},          32'(busy),          32'h0);
    endtask

    // Full single op on requester 0 alone, resp_ready high in RESP.
    task automatic run_r0(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        r0_req_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b;
        #1;
        check({tag, " req_ready"}, 32'(r0_req_ready), 32'h1);
        tick();
        r0_req_valid = 1'b0;
        check({tag, " exec busy"}, 32'(busy), 32'h1);
        check({tag, " exec resp_valid"}, 32'(r0_resp_valid), 32'h0);
        tick();
        check({tag, " resp_valid"}, 32'(r0_resp_valid), 32'h1);
        check({tag, " data"}, resp_data, exp);
        r0_resp_ready = 1'b1;
        tick();
        r0_resp_ready = 1'b0;
        check({tag, " back idle"}, 32'(busy), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        r0_req_valid = 1'b0; r0_op = 2'b00; r0_a = '0; r0_b = '0; r0_resp_ready = 1'b0;
        r1_req_valid = 1'b0; r1_op = 2'b00; r1_a = '0; r1_b = '0; r1_resp_ready = 1'b0;

        // Reset
        tick(); tick();
        rst_n = 1'b1;
        check_idle_outputs("reset");
        check("reset resp_data", resp_data, 32'h0);
        tick();
        check_idle_outputs("post-reset idle");

        // Single request: r0 XOR
        r0_req_valid = 1'b1; r0_op = 2'b10; r0_a = 32'h0000_00F0; r0_b = 32'h0000_00FF;
        #1;
        check("single r0_req_ready", 32'(r0_req_ready), 32'h1);
        check("single r1_req_ready", 32'(r1_req_ready), 32'h0);
        tick();
        r0_req_valid = 1'b0;
        check("single exec busy", 32'(busy), 32'h1);
        check("single exec resp_valid", 32'(r0_resp_valid), 32'h0);
        tick();
        check("single r0_resp_valid", 32'(r0_resp_valid), 32'h1);
        check("single r1_resp_valid", 32'(r1_resp_valid), 32'h0);
        check("single data", resp_data, 32'h0000_000F);
        r0_resp_ready = 1'b1;
        tick();
        r0_resp_ready = 1'b0;
        check_idle_outputs("single done");

        // Backpressure: tie after r0 served goes to r1; r0 waits throughout
        r1_req_valid = 1'b1; r1_op = 2'b11; r1_a = 32'h0000_000F; r1_b = 32'h0000_00FF;
        r0_req_valid = 1'b1; r0_op = 2'b00; r0_a = 32'h0000_00FF; r0_b = 32'h0000_00AA;
        #1;
        check("bp r1_req_ready", 32'(r1_req_ready), 32'h1);
        check("bp r0_req_ready", 32'(r0_req_ready), 32'h0);
        tick();
        r1_req_valid = 1'b0;
        check("bp exec r0_req_ready", 32'(r0_req_ready), 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp hold%0d r1_resp_valid", i), 32'(r1_resp_valid), 32'h1);
            check($sformatf("bp hold%0d data", i), resp_data, 32'hFFFF_FF00);
            check($sformatf("bp hold%0d r0_req_ready", i), 32'(r0_req_ready), 32'h0);
            check($sformatf("bp hold%0d r0_resp_valid", i), 32'(r0_resp_valid), 32'h0);
            // Non-owner resp_ready must be ignored
            r0_resp_ready = (i == 2);
            tick();
        end
        r0_resp_ready = 1'b0;
        check("bp still held", 32'(r1_resp_valid), 32'h1);
        r1_resp_ready = 1'b1;
        tick();
        check("bp released r1_resp_valid", 32'(r1_resp_valid), 32'h0);

        // Contention: both valid, resp_ready tied high, grants alternate 0,1,0,1
        r1_req_valid = 1'b1; r1_op = 2'b01; r1_a = 32'h0000_000F; r1_b = 32'h0000_00F0;
        r0_resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic exp_g;
            exp_g = (k % 2) == 1;
            #1;
            check($sformatf("cont%0d r0_req_ready", k), 32'(r0_req_ready), 32'(!exp_g));
            check($sformatf("cont%0d r1_req_ready", k), 32'(r1_req_ready), 32'(exp_g));
            tick();
            tick();
            check($sformatf("cont%0d r0_resp_valid", k), 32'(r0_resp_valid), 32'(!exp_g));
            check($sformatf("cont%0d r1_resp_valid", k), 32'(r1_resp_valid), 32'(exp_g));
            check($sformatf("cont%0d data", k), resp_data, exp_g ? 32'h0000_00FF : 32'h0000_00AA);
            tick();
        end
        r0_req_valid = 1'b0; r1_req_valid = 1'b0;
        r0_resp_ready = 1'b0; r1_resp_ready = 1'b0;
        tick();
        check_idle_outputs("cont done");

        // Reset mid-op: r1 accepted, reset during EXEC
        r1_req_valid = 1'b1; r1_op = 2'b10; r1_a = 32'h1234_5678; r1_b = 32'hFFFF_FFFF;
        #1;
        check("midrst r1_req_ready", 32'(r1_req_ready), 32'h1);
        tick();
        r1_req_valid = 1'b0;
        check("midrst in exec", 32'(busy), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_idle_outputs($sformatf("midrst after%0d", i));
            check($sformatf("midrst after%0d data", i), resp_data, 32'h0);
            tick();
        end

        // After reset a tie goes to requester 0
        r1_req_valid = 1'b1; r1_op = 2'b00; r1_a = 32'hFFFF_FFFF; r1_b = 32'hFFFF_FFFF;
        r0_req_valid = 1'b1; r0_op = 2'b00; r0_a = 32'hFFFF_0000; r0_b = 32'hFF00_FF00;
        #1;
        check("postrst r0_req_ready", 32'(r0_req_ready), 32'h1);
        check("postrst r1_req_ready", 32'(r1_req_ready), 32'h0);
        r1_req_valid = 1'b0;
        r0_req_valid = 1'b0;
        #1;

        // All four ops
        run_r0("op AND", 2'b00, 32'hFFFF_0000, 32'hFF00_FF00, 32'hFF00_0000);
        run_r0("op OR",  2'b01, 32'hFFFF_0000, 32'hFF00_FF00, 32'hFFFF_FF00);
        run_r0("op XOR", 2'b10, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00);
        run_r0("op NOR", 2'b11, 32'hFFFF_0000, 32'hFF00_FF00, 32'h0000_00FF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
